// File: rtl/tl45_pkg.sv
// Shared opcode encodings, state type and defaults for the TL45 multiply/divide unit.
package tl45_pkg;
  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] MD_MUL   = 3'b000;
  localparam logic [2:0] MD_MULH  = 3'b001;
  localparam logic [2:0] MD_MULHU = 3'b011;
  localparam logic [2:0] MD_DIV   = 3'b100;
  localparam logic [2:0] MD_DIVU  = 3'b101;
  localparam logic [2:0] MD_REM   = 3'b110;
  localparam logic [2:0] MD_REMU  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_e;

  // 3'b010 is the only unassigned code and is treated as a NOP.
  function automatic logic md_op_ok(input logic [2:0] op);
    return op != 3'b010;
  endfunction

  function automatic logic md_op_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction
endpackage

// File: rtl/tl45_muldiv_iter.sv
// Radix-2 iteration datapath: shift-add multiply and restoring divide on unsigned magnitudes.
module tl45_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi_nxt,
  output logic [WIDTH-1:0] o_lo_nxt
);
  logic [WIDTH-1:0] hi_q = '0;
  logic [WIDTH-1:0] lo_q = '0;
  logic [WIDTH-1:0] b_q  = '0;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   sum_d;
  logic             ge_d;

  // Multiply keeps {hi,lo} = partial product / remaining multiplier; divide keeps {hi,lo} = remainder / quotient.
  always_comb begin
    sum_d = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    ge_d  = {hi_q, lo_q[WIDTH-1]} >= {1'b0, b_q};
    if (i_div) begin
      hi_d = ge_d ? ({hi_q[WIDTH-2:0], lo_q[WIDTH-1]} - b_q) : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      lo_d = {lo_q[WIDTH-2:0], ge_d};
    end else begin
      hi_d = sum_d[WIDTH:1];
      lo_d = {sum_d[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      hi_q <= '0;
      lo_q <= i_a;
      b_q  <= i_b;
    end else if (i_step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign o_hi_nxt = hi_d;
  assign o_lo_nxt = lo_d;
endmodule

// File: rtl/tl45_muldiv.sv
// TL45 iterative multiply/divide unit: FSM, sign handling and pipeline handshake.
module tl45_muldiv
  import tl45_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DR_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic [2:0]       i_op,
  input  logic [DR_W-1:0]  i_dr,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_pipe_stall,
  input  logic             i_pipe_flush,
  output logic             o_pipe_stall,
  output logic             o_pipe_flush,
  output logic             o_valid,
  output logic [DR_W-1:0]  o_dr,
  output logic [WIDTH-1:0] o_value,
  output logic [DR_W-1:0]  o_of_reg,
  output logic [WIDTH-1:0] o_of_val
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e        state_q = S_IDLE;
  logic [CNT_W-1:0] cnt_q   = '0;
  logic [2:0]       op_q    = '0;
  logic [DR_W-1:0]  ldr_q   = '0;
  logic             q_neg_q = 1'b0;
  logic             r_neg_q = 1'b0;
  logic             valid_q = 1'b0;
  logic [DR_W-1:0]  dr_q    = '0;
  logic [WIDTH-1:0] value_q = '0;

  logic             accept, div0, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, hi_nxt, lo_nxt, value_d;

  // High half of -{hi,lo}: ~hi plus the carry that only appears when lo is zero.
  function automatic logic [WIDTH-1:0] fix_mulh(input logic [WIDTH-1:0] hi,
                                                input logic [WIDTH-1:0] lo,
                                                input logic neg);
    return neg ? (~hi + WIDTH'(lo == '0)) : hi;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign accept = i_valid && md_op_ok(i_op);
  assign div0   = i_op[2] && (i_b == '0);
  assign a_neg  = md_op_signed(i_op) && i_a[WIDTH-1];
  assign b_neg  = md_op_signed(i_op) && i_b[WIDTH-1];
  assign a_mag  = cond_neg(i_a, a_neg);
  assign b_mag  = cond_neg(i_b, b_neg);

  tl45_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_clk    (i_clk),
    .i_load   (state_q == S_IDLE && accept && !div0),
    .i_step   (state_q == S_RUN),
    .i_div    (op_q[2]),
    .i_a      (a_mag),
    .i_b      (b_mag),
    .o_hi_nxt (hi_nxt),
    .o_lo_nxt (lo_nxt)
  );

  // Result is taken from the final step's next-state values so it registers on DONE entry.
  always_comb begin
    value_d = lo_nxt;
    case (op_q)
      MD_MULH:           value_d = fix_mulh(hi_nxt, lo_nxt, q_neg_q);
      MD_MULHU, MD_REMU: value_d = hi_nxt;
      MD_DIV:            value_d = cond_neg(lo_nxt, q_neg_q);
      MD_REM:            value_d = cond_neg(hi_nxt, r_neg_q);
      default:           value_d = lo_nxt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_pipe_flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ldr_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      valid_q <= 1'b0;
      dr_q    <= '0;
      value_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= i_op;
            ldr_q   <= i_dr;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            cnt_q   <= '0;
            if (div0) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              dr_q    <= i_dr;
              value_q <= i_op[1] ? i_a : '1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            dr_q    <= ldr_q;
            value_q <= value_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (!i_pipe_stall) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            dr_q    <= '0;
            value_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_pipe_stall = i_pipe_stall || (state_q == S_IDLE && accept) || (state_q == S_RUN) ||
                        (state_q == S_DONE && i_pipe_stall);
  assign o_pipe_flush = i_pipe_flush;
  assign o_valid      = valid_q;
  assign o_dr         = dr_q;
  assign o_value      = value_q;
  assign o_of_reg     = dr_q;
  assign o_of_val     = value_q;
endmodule

// File: tb/tb_tl45_muldiv.sv
// Directed bench for tl45_muldiv with a cycle-level behavioural model and literal result checks.
module tb_tl45_muldiv;
  import tl45_pkg::*;

  localparam int W   = 32;
  localparam int DRW = 4;
  localparam logic [2:0] NOP_OP = 3'b010;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           valid = 1'b0;
  logic [2:0]     op = '0;
  logic [DRW-1:0] dr = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           stall = 1'b0;
  logic           flush = 1'b0;
  logic           o_pipe_stall, o_pipe_flush, o_valid;
  logic [DRW-1:0] o_dr, o_of_reg;
  logic [W-1:0]   o_value, o_of_val;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tl45_muldiv #(.WIDTH(W), .DR_W(DRW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_op(op), .i_dr(dr),
    .i_a(a), .i_b(b), .i_pipe_stall(stall), .i_pipe_flush(flush),
    .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush), .o_valid(o_valid),
    .o_dr(o_dr), .o_value(o_value), .o_of_reg(o_of_reg), .o_of_val(o_of_val)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of each op, straight from integer arithmetic.
  function automatic logic [31:0] md_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint     sp;
    logic [63:0] up;
    int         sx, sy;
    sx = x;
    sy = y;
    case (f)
      MD_MUL:   begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
      MD_MULH:  begin sp = longint'(sx) * longint'(sy); return sp[63:32]; end
      MD_MULHU: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      MD_DIV:   if (y == 0) return '1;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                else return 32'(sx / sy);
      MD_DIVU:  return (y == 0) ? '1 : x / y;
      MD_REM:   if (y == 0) return x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                else return 32'(sx % sy);
      MD_REMU:  return (y == 0) ? x : x % y;
      default:  return 32'h0;
    endcase
  endfunction

  // Latency model: a result appears WIDTH edges after acceptance, or right away on divide by zero.
  int             m_busy = 0;
  bit             m_done = 1'b0;
  logic [31:0]    m_res = '0;
  logic [DRW-1:0] m_dr = '0;

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      m_busy <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (!stall) m_done <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_done <= 1'b1;
    end else if (valid && op != NOP_OP) begin
      m_res <= md_model(op, a, b);
      m_dr  <= dr;
      if (op[2] && b == 0) m_done <= 1'b1;
      else m_busy <= W;
    end
  end

  always @(negedge clk) begin : cmp
    logic exp_stall;
    exp_stall = stall || (!m_done && m_busy == 0 && valid && op != NOP_OP) || (m_busy > 0) ||
                (m_done && stall);
    chk("valid", o_valid, m_done);
    chk("value", o_value, m_done ? m_res : 32'h0);
    chk("dr", o_dr, m_done ? m_dr : '0);
    chk("of_reg", o_of_reg, m_done ? m_dr : '0);
    chk("of_val", o_of_val, m_done ? m_res : 32'h0);
    chk("pipe_stall", o_pipe_stall, exp_stall);
    chk("pipe_flush", o_pipe_flush, flush);
  end

  // Called just after a rising edge; returns just after the edge that releases DONE.
  task automatic run_op(input string name, input logic [2:0] f, input logic [DRW-1:0] d,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_val, input int exp_lat);
    int lat;
    valid = 1'b1; op = f; dr = d; a = x; b = y;
    @(posedge clk); #2;
    valid = 1'b0; op = 3'($urandom_range(0, 7)); dr = DRW'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_val"}, o_value, exp_val);
    chk({name, "_dr"}, o_dr, d);
    @(posedge clk); #2;
  endtask

  task automatic wait_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #2;
      if (o_valid) seen = 1'b1;
    end
    chk(name, seen, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_value", o_value, 32'h0);
    chk("rst_stall", o_pipe_stall, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_op("mul",      MD_MUL,   4'd3,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
    run_op("mulh_mn",  MD_MULH,  4'd4,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    run_op("mulhu_ff", MD_MULHU, 4'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
    run_op("mulh_neg", MD_MULH,  4'd6,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32);
    run_op("mul_2p32", MD_MUL,   4'd7,  32'h0001_0000, 32'h0001_0000, 32'h0,         32);
    run_op("mulhu_1",  MD_MULHU, 4'd8,  32'h0001_0000, 32'h0001_0000, 32'h1,         32);
    run_op("div_neg",  MD_DIV,   4'd9,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
    run_op("rem_neg",  MD_REM,   4'd10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
    run_op("divu",     MD_DIVU,  4'd11, 32'd100,       32'd7,         32'd14,        32);
    run_op("remu",     MD_REMU,  4'd12, 32'd100,       32'd7,         32'd2,         32);
    run_op("div_nd",   MD_DIV,   4'd13, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
    run_op("rem_nd",   MD_REM,   4'd14, 32'd7,         32'hFFFF_FFFE, 32'd1,         32);
    run_op("divu_1",   MD_DIVU,  4'd15, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32);
    run_op("div_z",    MD_DIV,   4'd1,  32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    run_op("rem_z",    MD_REM,   4'd2,  32'd5,         32'd0,         32'd5,         0);
    run_op("divu_z",   MD_DIVU,  4'd3,  32'd9,         32'd0,         32'hFFFF_FFFF, 0);
    run_op("remu_z",   MD_REMU,  4'd4,  32'd9,         32'd0,         32'd9,         0);
    run_op("div_ovf",  MD_DIV,   4'd5,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);
    run_op("rem_ovf",  MD_REM,   4'd6,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32);

    // Downstream stall while the result is held.
    valid = 1'b1; op = MD_MUL; dr = 4'd9; a = 32'd3; b = 32'd4;
    @(posedge clk); #2;
    valid = 1'b0;
    begin
      int lat;
      lat = 0;
      while (!o_valid && lat < 100) begin
        @(posedge clk); #2;
        lat++;
      end
      chk("stall_lat", lat, 32);
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk("stall_hold_valid", o_valid, 1'b1);
      chk("stall_hold_val", o_value, 32'd12);
      chk("stall_upstream", o_pipe_stall, 1'b1);
    end
    stall = 1'b0;
    #1;
    chk("stall_release_up", o_pipe_stall, 1'b0);
    @(posedge clk); #2;
    chk("stall_released", o_valid, 1'b0);

    // Flush in cycle 10 of a MUL, then a fresh op the next cycle.
    valid = 1'b1; op = MD_MUL; dr = 4'd2; a = 32'd7; b = 32'd9;
    @(posedge clk); #2;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    flush = 1'b1;
    #1;
    chk("flush_fwd", o_pipe_flush, 1'b1);
    @(posedge clk); #2;
    flush = 1'b0;
    chk("flush_killed", o_valid, 1'b0);
    run_op("post_flush", MD_MUL, 4'd6, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);

    // Reset in cycle 10 of a MUL, then a fresh op the next cycle.
    valid = 1'b1; op = MD_MUL; dr = 4'd2; a = 32'd7; b = 32'd9;
    @(posedge clk); #2;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk("reset_killed", o_valid, 1'b0);
    run_op("post_reset", MD_DIVU, 4'd7, 32'd100, 32'd7, 32'd14, 32);

    // Flush wins over acceptance in the same cycle.
    valid = 1'b1; op = MD_MUL; dr = 4'd1; a = 32'd2; b = 32'd3; flush = 1'b1;
    @(posedge clk); #2;
    valid = 1'b0; flush = 1'b0;
    wait_quiet("flush_prio", 40);

    // Unassigned opcode never produces a result.
    valid = 1'b1; op = NOP_OP; dr = 4'd1; a = 32'd2; b = 32'd3;
    @(posedge clk); #2;
    valid = 1'b0;
    wait_quiet("nop", 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000 reached");
    $fatal(1);
  end
endmodule
